// File: rtl/wtu_buf_ctrl_if.sv
// Bundle of the WTU buffer controller's stream and buffer-port signals.
// master is the controller side, slave is the surrounding stream/buffer side.
interface wtu_buf_ctrl_if #(
   parameter int WR_WIDTH = 24,
   parameter int WR_DEPTH = 8
);
   localparam int RD_DEPTH = WR_DEPTH / 2;
   localparam int RD_WIDTH = 2 * WR_WIDTH;
   localparam int WA       = $clog2(WR_DEPTH);
   localparam int RA       = (RD_DEPTH > 1) ? $clog2(RD_DEPTH) : 1;

   logic                in_valid;
   logic [WR_WIDTH-1:0] in_data;
   logic                in_ready;

   logic                out_valid;
   logic [RD_WIDTH-1:0] out_data;
   logic                out_ready;

   logic                mem_wr_en;
   logic [WA-1:0]       mem_wr_addr;
   logic [WR_WIDTH-1:0] mem_wr_data;
   logic [RA-1:0]       mem_rd_addr;
   logic [RD_WIDTH-1:0] mem_rd_data;

   modport master (
      input  in_valid, in_data, out_ready, mem_rd_data,
      output in_ready, out_valid, out_data,
      output mem_wr_en, mem_wr_addr, mem_wr_data, mem_rd_addr
   );

   modport slave (
      output in_valid, in_data, out_ready, mem_rd_data,
      input  in_ready, out_valid, out_data,
      input  mem_wr_en, mem_wr_addr, mem_wr_data, mem_rd_addr
   );
endinterface

// File: rtl/wtu_buf_ctrl.sv
// Sequencer for the WTU dual-width sample buffer: fills the buffer with one
// frame of narrow samples, then drains it as paired wide words (odd sample
// in the upper half) with no bubble at either turnaround.
module wtu_buf_ctrl #(
   parameter int WR_WIDTH = 24,
   parameter int WR_DEPTH = 8
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           flush,
   wtu_buf_ctrl_if.master bus,
   output logic           busy,
   output logic [15:0]    frame_cnt
);
   localparam int RD_DEPTH = WR_DEPTH / 2;
   localparam int RD_WIDTH = 2 * WR_WIDTH;
   localparam int WA       = $clog2(WR_DEPTH);
   localparam int RA       = (RD_DEPTH > 1) ? $clog2(RD_DEPTH) : 1;

   localparam logic [WA-1:0] WR_LAST = WA'(WR_DEPTH - 1);
   localparam logic [RA-1:0] RD_LAST = RA'(RD_DEPTH - 1);

   typedef enum logic {
      FILL  = 1'b0,
      DRAIN = 1'b1
   } state_t;

   state_t              state;
   state_t              state_nxt;
   logic [WA-1:0]       wr_cnt;
   logic [RA-1:0]       rd_cnt;
   logic                wr_hs;
   logic                rd_hs;
   logic                wr_last;
   logic                rd_last;
   logic [RD_WIDTH-1:0] rd_word;

   // Qualified handshakes: flush overrides any transfer happening in the same cycle.
   always_comb begin
      wr_hs   = (state == FILL) && bus.in_valid && !flush;
      rd_hs   = (state == DRAIN) && bus.out_ready && !flush;
      wr_last = wr_hs && (wr_cnt == WR_LAST);
      rd_last = rd_hs && (rd_cnt == RD_LAST);
   end

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= FILL;
      end else begin
         state <= state_nxt;
      end
   end

   // Next state: the final write or final pair read flips direction; flush always returns to FILL.
   always_comb begin
      state_nxt = state;
      if (flush) begin
         state_nxt = FILL;
      end else begin
         case (state)
            FILL:    if (wr_last) state_nxt = DRAIN;
            DRAIN:   if (rd_last) state_nxt = FILL;
            default: state_nxt = FILL;
         endcase
      end
   end

   // Write and read pointers, wrapping to zero on the last beat of each phase.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_cnt <= '0;
         rd_cnt <= '0;
      end else if (flush) begin
         wr_cnt <= '0;
         rd_cnt <= '0;
      end else begin
         if (wr_hs) begin
            wr_cnt <= wr_last ? '0 : wr_cnt + 1'b1;
         end
         if (rd_hs) begin
            rd_cnt <= rd_last ? '0 : rd_cnt + 1'b1;
         end
      end
   end

   // Completed-frame counter; a flushed final read does not qualify as rd_last.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         frame_cnt <= '0;
      end else if (rd_last) begin
         frame_cnt <= frame_cnt + 16'd1;
      end
   end

   // Outputs are pure decodes of state and pointers so read data is valid with out_valid.
   always_comb begin
      bus.in_ready    = (state == FILL);
      bus.mem_wr_en   = wr_hs;
      bus.mem_wr_data = bus.in_data;
      bus.mem_wr_addr = wr_cnt;
      bus.out_valid   = (state == DRAIN);
      busy            = (state == DRAIN);
      bus.mem_rd_addr = (RD_DEPTH > 1) ? rd_cnt : '0;
      rd_word         = bus.mem_rd_data;
      bus.out_data    = rd_word;
   end
endmodule

// File: tb/tb_wtu_buf_ctrl.sv
// Self-checking bench for wtu_buf_ctrl: the bench also plays the sample
// buffer, and a frame-level model (queue of accepted samples) predicts
// every output each cycle.
module tb_wtu_buf_ctrl;
   localparam int WR_WIDTH = 24;
   localparam int WR_DEPTH = 8;
   localparam int RD_DEPTH = WR_DEPTH / 2;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        flush = 1'b0;
   logic        busy;
   logic [15:0] frame_cnt;

   int errCount = 0;
   int checkCount = 0;

   wtu_buf_ctrl_if #(.WR_WIDTH(WR_WIDTH), .WR_DEPTH(WR_DEPTH)) bus ();

   wtu_buf_ctrl #(.WR_WIDTH(WR_WIDTH), .WR_DEPTH(WR_DEPTH)) dut (
      .clk       (clk),
      .rst       (rst),
      .flush     (flush),
      .bus       (bus.master),
      .busy      (busy),
      .frame_cnt (frame_cnt)
   );

   always #5 clk = ~clk;

   // The sample buffer: synchronous write, combinational paired read.
   logic [WR_WIDTH-1:0] memArr [0:WR_DEPTH-1];

   always @(posedge clk) begin
      if (bus.mem_wr_en) memArr[bus.mem_wr_addr] <= bus.mem_wr_data;
   end

   assign bus.mem_rd_data = {memArr[{bus.mem_rd_addr, 1'b1}], memArr[{bus.mem_rd_addr, 1'b0}]};

   // Frame-level reference model.
   logic [WR_WIDTH-1:0] mAcc[$];
   bit                  mDrain = 1'b0;
   int                  mPairs = 0;
   int                  mFrames = 0;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         mAcc.delete();
         mDrain = 1'b0;
         mPairs = 0;
         mFrames = 0;
      end else if (flush) begin
         mAcc.delete();
         mDrain = 1'b0;
         mPairs = 0;
      end else if (!mDrain) begin
         if (bus.in_valid) begin
            mAcc.push_back(bus.in_data);
            if (mAcc.size() == WR_DEPTH) begin
               mDrain = 1'b1;
               mPairs = 0;
            end
         end
      end else if (bus.out_ready) begin
         mPairs++;
         if (mPairs == RD_DEPTH) begin
            mDrain = 1'b0;
            mPairs = 0;
            mAcc.delete();
            mFrames = (mFrames + 1) % 65536;
         end
      end
   end

   task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
      checkCount++;
      if (act !== exp) begin
         errCount++;
         $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic applyStimulus(input bit v, input logic [WR_WIDTH-1:0] d, input bit f, input bit r);
      @(posedge clk);
      #1;
      bus.in_valid  = v;
      bus.in_data   = d;
      flush         = f;
      bus.out_ready = r;
   endtask

   task automatic fillFrame();
      for (int i = 0; i < WR_DEPTH; i++) applyStimulus(1'b1, WR_WIDTH'($urandom), 1'b0, 1'b1);
   endtask

   task automatic drainFrame();
      for (int i = 0; i < RD_DEPTH; i++) applyStimulus(1'b0, '0, 1'b0, 1'b1);
      applyStimulus(1'b0, '0, 1'b0, 1'b0);
   endtask

   // Per-cycle comparison of every DUT output against the model.
   always @(negedge clk) begin
      logic wrEnExp;
      wrEnExp = !mDrain && bus.in_valid && !flush;
      checkOutput("in_ready", 64'(bus.in_ready), 64'(!mDrain));
      checkOutput("out_valid", 64'(bus.out_valid), 64'(mDrain));
      checkOutput("busy", 64'(busy), 64'(mDrain));
      checkOutput("mem_wr_en", 64'(bus.mem_wr_en), 64'(wrEnExp));
      checkOutput("mem_wr_addr", 64'(bus.mem_wr_addr), mDrain ? 64'd0 : 64'(mAcc.size()));
      checkOutput("mem_rd_addr", 64'(bus.mem_rd_addr), mDrain ? 64'(mPairs) : 64'd0);
      checkOutput("frame_cnt", 64'(frame_cnt), 64'(mFrames));
      if (wrEnExp) checkOutput("mem_wr_data", 64'(bus.mem_wr_data), 64'(bus.in_data));
      if (mDrain) checkOutput("out_data", 64'(bus.out_data), 64'({mAcc[2*mPairs+1], mAcc[2*mPairs]}));
   end

   logic [47:0] pairLit [0:3];
   bit          readyPat [0:3];
   bit          validPat [0:4];

   initial begin
      pairLit[0] = 48'h000002_000001;
      pairLit[1] = 48'h000004_000003;
      pairLit[2] = 48'h000006_000005;
      pairLit[3] = 48'h000008_000007;
      readyPat[0] = 1'b1; readyPat[1] = 1'b0; readyPat[2] = 1'b0; readyPat[3] = 1'b1;
      validPat[0] = 1'b1; validPat[1] = 1'b0; validPat[2] = 1'b1; validPat[3] = 1'b1; validPat[4] = 1'b0;

      bus.in_valid  = 1'b0;
      bus.in_data   = '0;
      bus.out_ready = 1'b0;
      flush         = 1'b0;
      #1 rst = 1'b1;
      #1;
      checkOutput("rst_in_ready", 64'(bus.in_ready), 64'd1);
      checkOutput("rst_out_valid", 64'(bus.out_valid), 64'd0);
      checkOutput("rst_frame_cnt", 64'(frame_cnt), 64'd0);
      checkOutput("rst_wr_addr", 64'(bus.mem_wr_addr), 64'd0);
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;

      // Straight fill of 1..8 then full-rate drain with literal pair values.
      for (int i = 0; i < WR_DEPTH; i++) applyStimulus(1'b1, WR_WIDTH'(i + 1), 1'b0, 1'b1);
      for (int p = 0; p < RD_DEPTH; p++) begin
         applyStimulus(1'b0, '0, 1'b0, 1'b1);
         @(negedge clk); #1;
         checkOutput("t1_pair", 64'(bus.out_data), 64'(pairLit[p]));
      end
      applyStimulus(1'b0, '0, 1'b0, 1'b0);
      @(negedge clk); #1;
      checkOutput("t1_in_ready", 64'(bus.in_ready), 64'd1);
      checkOutput("t1_frame_cnt", 64'(frame_cnt), 64'd1);

      // Drain with a stalling consumer.
      fillFrame();
      for (int i = 0; i < 8; i++) applyStimulus(1'b0, '0, 1'b0, readyPat[i % 4]);
      applyStimulus(1'b0, '0, 1'b0, 1'b0);
      @(negedge clk); #1;
      checkOutput("t2_frame_cnt", 64'(frame_cnt), 64'd2);
      checkOutput("t2_in_ready", 64'(bus.in_ready), 64'd1);

      // Gappy input stream.
      begin
         int accepted = 0;
         for (int i = 0; i < 40 && accepted < WR_DEPTH; i++) begin
            applyStimulus(validPat[i % 5], WR_WIDTH'($urandom), 1'b0, 1'b1);
            if (validPat[i % 5]) accepted++;
         end
      end
      drainFrame();
      @(negedge clk); #1;
      checkOutput("t3_frame_cnt", 64'(frame_cnt), 64'd3);

      // Flush on the fifth accept.
      for (int i = 0; i < 4; i++) applyStimulus(1'b1, WR_WIDTH'($urandom), 1'b0, 1'b1);
      applyStimulus(1'b1, WR_WIDTH'($urandom), 1'b1, 1'b1);
      @(negedge clk); #1;
      checkOutput("t4_wr_en_flushed", 64'(bus.mem_wr_en), 64'd0);
      applyStimulus(1'b0, '0, 1'b0, 1'b1);
      @(negedge clk); #1;
      checkOutput("t4_wr_addr", 64'(bus.mem_wr_addr), 64'd0);
      checkOutput("t4_frame_cnt", 64'(frame_cnt), 64'd3);
      fillFrame();
      drainFrame();
      @(negedge clk); #1;
      checkOutput("t4_next_frame", 64'(frame_cnt), 64'd4);

      // Asynchronous reset mid-drain after two pairs.
      fillFrame();
      applyStimulus(1'b0, '0, 1'b0, 1'b1);
      applyStimulus(1'b0, '0, 1'b0, 1'b1);
      @(posedge clk);
      #2 rst = 1'b1;
      #1;
      checkOutput("t5_out_valid", 64'(bus.out_valid), 64'd0);
      checkOutput("t5_busy", 64'(busy), 64'd0);
      checkOutput("t5_in_ready", 64'(bus.in_ready), 64'd1);
      checkOutput("t5_rd_addr", 64'(bus.mem_rd_addr), 64'd0);
      checkOutput("t5_frame_cnt", 64'(frame_cnt), 64'd0);
      @(posedge clk);
      #1 rst = 1'b0;
      fillFrame();
      drainFrame();
      @(negedge clk); #1;
      checkOutput("t5_after_frame", 64'(frame_cnt), 64'd1);

      // Flush coincident with the final drain handshake.
      fillFrame();
      for (int i = 0; i < RD_DEPTH - 1; i++) applyStimulus(1'b0, '0, 1'b0, 1'b1);
      applyStimulus(1'b0, '0, 1'b1, 1'b1);
      applyStimulus(1'b0, '0, 1'b0, 1'b0);
      @(negedge clk); #1;
      checkOutput("t6_frame_cnt", 64'(frame_cnt), 64'd1);
      checkOutput("t6_in_ready", 64'(bus.in_ready), 64'd1);

      // Randomized traffic against the model.
      for (int i = 0; i < 3000; i++) begin
         applyStimulus(($urandom % 4) != 0, WR_WIDTH'($urandom), ($urandom % 64) == 0, ($urandom % 3) != 0);
      end
      applyStimulus(1'b0, '0, 1'b0, 1'b0);
      @(negedge clk); #1;

      $display("Result: errors=%0d of %0d checks", errCount, checkCount);
      $finish;
   end
endmodule
